uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to add the parity bit (sense set by P_PARITY_ODD).
module uart_tx_ctrl #(
    parameter int P_CLK_FRQ    = 48_000_000,
    parameter int P_BAURATE    = 9600,
    parameter int P_DATA_W     = 8,
    parameter int P_STOP_BITS  = 1,
    parameter int P_PARITY_ODD = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [P_DATA_W-1:0] TX_DATA,
    input  logic                TX_VALID,
    output logic                TX_READY,
    output logic                UART_TX,
    output logic                BUSY,
    output logic                TX_DONE
);

    localparam int LP_DIV = P_CLK_FRQ / P_BAURATE;
    localparam int LP_CW  = (LP_DIV < 2) ? 1 : $clog2(LP_DIV);
    localparam int LP_BW  = $clog2(P_DATA_W + 1);

    localparam logic [LP_CW-1:0] LP_BAUD_LAST = LP_CW'(LP_DIV - 1);
    localparam logic [LP_CW-1:0] LP_BAUD_PRE  = LP_CW'(LP_DIV - 2);
    localparam logic [LP_BW-1:0] LP_DATA_LAST = LP_BW'(P_DATA_W - 1);
    localparam logic [LP_BW-1:0] LP_STOP_LAST = LP_BW'(P_STOP_BITS - 1);

    if (LP_DIV < 2) begin : g_err_div
        $error("uart_tx_ctrl: P_CLK_FRQ/P_BAURATE must be at least 2");
    end
    if (P_DATA_W < 5 || P_DATA_W > 9) begin : g_err_data_w
        $error("uart_tx_ctrl: P_DATA_W must be 5..9");
    end
    if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_err_stop
        $error("uart_tx_ctrl: P_STOP_BITS must be 1 or 2");
    end
    if (P_PARITY_ODD < 0 || P_PARITY_ODD > 1) begin : g_err_parity
        $error("uart_tx_ctrl: P_PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [LP_CW-1:0]    r_baud;
    logic [LP_BW-1:0]    r_bit;
    logic [P_DATA_W-1:0] r_shift;
    logic                r_tx;
    logic                r_done;
    logic                w_baud_last;

`ifdef UART_TX_PARITY_EN
    localparam logic LP_ODD = (P_PARITY_ODD != 0);
    logic            r_parity;
`endif

    assign w_baud_last = (r_baud == LP_BAUD_LAST);

    assign TX_READY = (r_state == S_IDLE);
    assign BUSY     = (r_state != S_IDLE);
    assign UART_TX  = r_tx;
    assign TX_DONE  = r_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (TX_VALID) begin
                        r_shift  <= TX_DATA;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^TX_DATA) ^ LP_ODD;
`endif
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_tx     <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + LP_CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == LP_DATA_LAST) begin
                            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + LP_BW'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + LP_CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + LP_CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // Registered pulse: raised one cycle early so it lands on the final stop cycle.
                    if (r_bit == LP_STOP_LAST && r_baud == LP_BAUD_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == LP_STOP_LAST) begin
                            r_bit   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + LP_BW'(1);
                        end
                    end else begin
                        r_baud <= r_baud + LP_CW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at DIV=10; covers both builds of UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [8:0] data = '0;
    logic       valid = 1'b0;
    int         sel = 0;

    logic a_tx, a_rdy, a_busy, a_done;
    logic b_tx, b_rdy, b_busy, b_done;
    logic c_tx, c_rdy, c_busy, c_done;
    logic m_tx, m_rdy, m_busy, m_done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.P_CLK_FRQ(1_000_000), .P_BAURATE(100_000), .P_DATA_W(8),
                   .P_STOP_BITS(1), .P_PARITY_ODD(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .TX_DATA(data[7:0]), .TX_VALID(valid && (sel == 0)),
        .TX_READY(a_rdy), .UART_TX(a_tx), .BUSY(a_busy), .TX_DONE(a_done));

    uart_tx_ctrl #(.P_CLK_FRQ(1_000_000), .P_BAURATE(100_000), .P_DATA_W(5),
                   .P_STOP_BITS(2), .P_PARITY_ODD(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .TX_DATA(data[4:0]), .TX_VALID(valid && (sel == 1)),
        .TX_READY(b_rdy), .UART_TX(b_tx), .BUSY(b_busy), .TX_DONE(b_done));

`ifdef UART_TX_PARITY_EN
    uart_tx_ctrl #(.P_CLK_FRQ(1_000_000), .P_BAURATE(100_000), .P_DATA_W(8),
                   .P_STOP_BITS(1), .P_PARITY_ODD(1)) dut_c (
        .CLK(CLK), .RESET(RESET), .TX_DATA(data[7:0]), .TX_VALID(valid && (sel == 2)),
        .TX_READY(c_rdy), .UART_TX(c_tx), .BUSY(c_busy), .TX_DONE(c_done));
`else
    assign c_tx = 1'b1;
    assign c_rdy = 1'b1;
    assign c_busy = 1'b0;
    assign c_done = 1'b0;
`endif

    always_comb begin
        case (sel)
            1: begin m_tx = b_tx; m_rdy = b_rdy; m_busy = b_busy; m_done = b_done; end
            2: begin m_tx = c_tx; m_rdy = c_rdy; m_busy = c_busy; m_done = c_done; end
            default: begin m_tx = a_tx; m_rdy = a_rdy; m_busy = a_busy; m_done = a_done; end
        endcase
    end

    // Expected line level per bit slot: start, data LSB first, optional parity, stops.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd, input bit odd);
        logic [15:0] b;
        logic        p;
        b = '1;
        b[0] = 1'b0;
        p = odd;
        for (int i = 0; i < nd; i++) begin
            b[1 + i] = d[i];
            p = p ^ d[i];
        end
        if (PB == 1) b[1 + nd] = p;
        return b;
    endfunction

    task automatic test_reset();
        sel = 0;
        valid = 1'b1;
        data = 9'h0FF;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        valid = 1'b0;
        checks++; if (a_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", a_tx); end
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_rdy); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
        checks++; if (b_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_b: got %b expected 1", b_tx); end
        checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b expected 1", b_rdy); end
    endtask

    task automatic test_8n1();
        logic [15:0] bits;
        int          fr;
        fr = (1 + 8 + PB + 1) * DIV;
        bits = frame_bits(9'h0A5, 8, 1'b0);
        sel = 0;
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL 8n1_ready_before: got %b expected 1", m_rdy); end
        data = 9'h0A5;
        valid = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= fr; n++) begin
            @(negedge CLK);
            if (n == 1) begin valid = 1'b0; data = 9'h05A; end
            checks++; if (m_tx !== bits[(n-1)/DIV]) begin errors++; $display("FAIL 8n1_line cycle %0d: got %b expected %b", n, m_tx, bits[(n-1)/DIV]); end
            checks++; if (m_done !== (n == fr)) begin errors++; $display("FAIL 8n1_done cycle %0d: got %b expected %b", n, m_done, (n == fr)); end
            checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL 8n1_busy cycle %0d: got %b expected 1", n, m_busy); end
        end
        @(negedge CLK);
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL 8n1_ready_after: got %b expected 1", m_rdy); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_after: got %b expected 0", m_busy); end
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL 8n1_done_after: got %b expected 0", m_done); end
        checks++; if (m_tx !== 1'b1) begin errors++; $display("FAIL 8n1_idle_line: got %b expected 1", m_tx); end
    endtask

    task automatic test_5n2();
        logic [15:0] bits;
        int          fr;
        fr = (1 + 5 + PB + 2) * DIV;
        bits = frame_bits(9'h01F, 5, 1'b0);
        sel = 1;
        @(negedge CLK);
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL 5n2_ready_before: got %b expected 1", m_rdy); end
        data = 9'h01F;
        valid = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= fr; n++) begin
            @(negedge CLK);
            if (n == 1) begin valid = 1'b0; data = 9'h000; end
            checks++; if (m_tx !== bits[(n-1)/DIV]) begin errors++; $display("FAIL 5n2_line cycle %0d: got %b expected %b", n, m_tx, bits[(n-1)/DIV]); end
            checks++; if (m_done !== (n == fr)) begin errors++; $display("FAIL 5n2_done cycle %0d: got %b expected %b", n, m_done, (n == fr)); end
        end
        @(negedge CLK);
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL 5n2_ready_after: got %b expected 1", m_rdy); end
        sel = 0;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] bits;
        logic        pexp;
        int          fr;
        fr = 110;
        for (int s = 0; s <= 2; s += 2) begin
            sel = s;
            pexp = (s == 2) ? 1'b0 : 1'b1;
            bits = frame_bits(9'h007, 8, (s == 2));
            @(negedge CLK);
            data = 9'h007;
            valid = 1'b1;
            @(posedge CLK);
            for (int n = 1; n <= fr; n++) begin
                @(negedge CLK);
                if (n == 1) valid = 1'b0;
                checks++; if (m_tx !== bits[(n-1)/DIV]) begin errors++; $display("FAIL par%0d_line cycle %0d: got %b expected %b", s, n, m_tx, bits[(n-1)/DIV]); end
                checks++; if (m_done !== (n == fr)) begin errors++; $display("FAIL par%0d_done cycle %0d: got %b expected %b", s, n, m_done, (n == fr)); end
                if (n == 95) begin
                    checks++; if (m_tx !== pexp) begin errors++; $display("FAIL par%0d_bit: got %b expected %b", s, m_tx, pexp); end
                end
            end
            @(negedge CLK);
        end
        sel = 0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] bits1, bits2;
        int          fr;
        fr = (1 + 8 + PB + 1) * DIV;
        bits1 = frame_bits(9'h055, 8, 1'b0);
        bits2 = frame_bits(9'h03C, 8, 1'b0);
        sel = 0;
        @(negedge CLK);
        data = 9'h055;
        valid = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= fr; n++) begin
            @(negedge CLK);
            if (n == 1) data = 9'h03C;
            checks++; if (m_tx !== bits1[(n-1)/DIV]) begin errors++; $display("FAIL b2b_first_line cycle %0d: got %b expected %b", n, m_tx, bits1[(n-1)/DIV]); end
            checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL b2b_first_busy cycle %0d: got %b expected 1", n, m_busy); end
        end
        @(negedge CLK);
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 1", m_rdy); end
        checks++; if (m_tx !== 1'b1) begin errors++; $display("FAIL b2b_gap_line: got %b expected 1", m_tx); end
        @(posedge CLK);
        for (int n = 1; n <= fr; n++) begin
            @(negedge CLK);
            if (n == 1) valid = 1'b0;
            checks++; if (m_tx !== bits2[(n-1)/DIV]) begin errors++; $display("FAIL b2b_second_line cycle %0d: got %b expected %b", n, m_tx, bits2[(n-1)/DIV]); end
            checks++; if (m_done !== (n == fr)) begin errors++; $display("FAIL b2b_second_done cycle %0d: got %b expected %b", n, m_done, (n == fr)); end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int seen_done;
        sel = 0;
        seen_done = 0;
        @(negedge CLK);
        data = 9'h052;
        valid = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 45; n++) begin
            @(negedge CLK);
            if (n == 1) valid = 1'b0;
        end
        checks++; if (m_tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b expected 0", m_tx); end
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        checks++; if (m_tx !== 1'b1) begin errors++; $display("FAIL rstmid_line: got %b expected 1", m_tx); end
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", m_rdy); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", m_busy); end
        for (int n = 0; n < 120; n++) begin
            if (m_done !== 1'b0) seen_done++;
            @(negedge CLK);
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_5n2();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
